// File: rtl/ahbl_periph_splitter.sv
// AHB-Lite peripheral splitter: decodes one HADDR field into per-slave selects,
// muxes the data-phase response and acts as default slave with error logging.
module ahbl_periph_splitter #(
  parameter int unsigned                       NS       = 5,
  parameter int unsigned                       DEC_HI   = 27,
  parameter int unsigned                       DEC_LO   = 24,
  parameter logic [NS*(DEC_HI-DEC_LO+1)-1:0]   SLV_IDS  = {(DEC_HI-DEC_LO+1)'(3'h4),
                                                           (DEC_HI-DEC_LO+1)'(3'h3),
                                                           (DEC_HI-DEC_LO+1)'(3'h2),
                                                           (DEC_HI-DEC_LO+1)'(3'h1),
                                                           (DEC_HI-DEC_LO+1)'(3'h0)},
  parameter logic [31:0]                       BAD_DATA = 32'hBADDBEEF
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  output logic             HREADY,
  output logic             HRESP,
  output logic [31:0]      HRDATA,
  output logic [NS-1:0]    S_SEL,
  input  logic [NS*32-1:0] S_HRDATA,
  input  logic [NS-1:0]    S_HREADYOUT,
  input  logic [NS-1:0]    S_HRESP,
  input  logic             err_clr,
  output logic             err_irq,
  output logic [31:0]      err_addr,
  output logic [7:0]       err_cnt
);

  localparam int unsigned DW = DEC_HI - DEC_LO + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ERR1,
    ST_ERR2
  } state_e;

  state_e          state_q, state_d;
  logic [NS-1:0]   dph_sel_q, dph_sel_d;
  logic            err_irq_q, err_irq_d;
  logic [31:0]     err_addr_q, err_addr_d;
  logic [7:0]      err_cnt_q, err_cnt_d;

  logic [DW-1:0]   dec_fld;
  logic [NS-1:0]   s_sel_c;
  logic            hit_c;
  logic            acc_c;
  logic            unm_c;
  logic            unused_htrans0;

  assign dec_fld        = HADDR[DEC_HI:DEC_LO];
  assign unused_htrans0 = HTRANS[0];

  // Priority decode: lowest index wins when IDs are duplicated.
  always_comb begin
    s_sel_c = '0;
    hit_c   = 1'b0;
    for (int i = 0; i < int'(NS); i++) begin
      if (!hit_c && (dec_fld == SLV_IDS[i*DW +: DW])) begin
        s_sel_c[i] = 1'b1;
        hit_c      = 1'b1;
      end
    end
  end

  assign S_SEL = HSEL ? s_sel_c : '0;

  // Response mux; the default-slave error states override the slave path.
  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = BAD_DATA;
    for (int i = 0; i < int'(NS); i++) begin
      if (dph_sel_q[i]) begin
        HREADY = S_HREADYOUT[i];
        HRESP  = S_HRESP[i];
        HRDATA = S_HRDATA[i*32 +: 32];
      end
    end
    case (state_q)
      ST_ERR1: begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
        HRDATA = BAD_DATA;
      end
      ST_ERR2: begin
        HREADY = 1'b1;
        HRESP  = 1'b1;
        HRDATA = BAD_DATA;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    dph_sel_d  = dph_sel_q;
    err_irq_d  = err_irq_q;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;

    acc_c = HSEL & HTRANS[1] & HREADY;
    unm_c = acc_c & ~hit_c;

    if (HREADY) begin
      dph_sel_d = acc_c ? S_SEL : '0;
    end

    case (state_q)
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    if (unm_c) begin
      state_d = ST_ERR1;
    end

    // Clear first so a coincident unmapped access is logged as the new first error.
    if (err_clr) begin
      err_irq_d  = 1'b0;
      err_addr_d = '0;
      err_cnt_d  = '0;
    end
    if (unm_c) begin
      if (err_cnt_d != 8'hFF) begin
        err_cnt_d = err_cnt_d + 8'd1;
      end
      if (!err_irq_d) begin
        err_irq_d  = 1'b1;
        err_addr_d = HADDR;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      dph_sel_q  <= '0;
      err_irq_q  <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      dph_sel_q  <= dph_sel_d;
      err_irq_q  <= err_irq_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign err_irq  = err_irq_q;
  assign err_addr = err_addr_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_ahbl_periph_splitter.sv
// Directed bench for ahbl_periph_splitter: default config plus a
// 2-slave, 1-bit-field instance with duplicate IDs.
module tb_ahbl_periph_splitter;

  logic         hclk;
  logic         hresetn;
  logic         hsel;
  logic [31:0]  haddr;
  logic [1:0]   htrans;
  logic         err_clr;

  logic         hready, hresp;
  logic [31:0]  hrdata;
  logic [4:0]   s_sel;
  logic [159:0] s_hrdata;
  logic [4:0]   s_hreadyout;
  logic [4:0]   s_hresp;
  logic         err_irq;
  logic [31:0]  err_addr;
  logic [7:0]   err_cnt;

  logic         b_hready, b_hresp;
  logic [31:0]  b_hrdata;
  logic [1:0]   b_sel;
  logic [63:0]  b_s_hrdata;
  logic [1:0]   b_s_hreadyout;
  logic [1:0]   b_s_hresp;
  logic         b_err_irq;
  logic [31:0]  b_err_addr;
  logic [7:0]   b_err_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [31:0] BAD     = 32'hBADDBEEF;

  ahbl_periph_splitter u_dut (
    .HCLK        (hclk),
    .HRESETn     (hresetn),
    .HSEL        (hsel),
    .HADDR       (haddr),
    .HTRANS      (htrans),
    .HREADY      (hready),
    .HRESP       (hresp),
    .HRDATA      (hrdata),
    .S_SEL       (s_sel),
    .S_HRDATA    (s_hrdata),
    .S_HREADYOUT (s_hreadyout),
    .S_HRESP     (s_hresp),
    .err_clr     (err_clr),
    .err_irq     (err_irq),
    .err_addr    (err_addr),
    .err_cnt     (err_cnt)
  );

  ahbl_periph_splitter #(
    .NS      (2),
    .DEC_HI  (24),
    .DEC_LO  (24),
    .SLV_IDS (2'b00)
  ) u_dup (
    .HCLK        (hclk),
    .HRESETn     (hresetn),
    .HSEL        (hsel),
    .HADDR       (haddr),
    .HTRANS      (htrans),
    .HREADY      (b_hready),
    .HRESP       (b_hresp),
    .HRDATA      (b_hrdata),
    .S_SEL       (b_sel),
    .S_HRDATA    (b_s_hrdata),
    .S_HREADYOUT (b_s_hreadyout),
    .S_HRESP     (b_s_hresp),
    .err_clr     (err_clr),
    .err_irq     (b_err_irq),
    .err_addr    (b_err_addr),
    .err_cnt     (b_err_cnt)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input logic sel, input logic [1:0] trans, input logic [31:0] addr);
    hsel   = sel;
    htrans = trans;
    haddr  = addr;
  endtask

  initial begin
    hresetn       = 1'b0;
    err_clr       = 1'b0;
    drive(1'b1, T_IDLE, 32'h0200_0000);
    s_hreadyout   = 5'b11111;
    s_hresp       = 5'b00000;
    s_hrdata      = {32'h5555_0004, 32'h0000_0000, 32'h5555_0002, 32'hA5A5_0001, 32'h5555_0000};
    b_s_hreadyout = 2'b11;
    b_s_hresp     = 2'b00;
    b_s_hrdata    = {32'hB000_0001, 32'hB000_0000};

    // Reset state and combinational decode while in reset
    tick();
    tick();
    @(negedge hclk);
    check("rst_hready", 32'(hready), 32'd1);
    check("rst_hresp",  32'(hresp), 32'd0);
    check("rst_hrdata", hrdata, BAD);
    check("rst_irq",    32'(err_irq), 32'd0);
    check("rst_cnt",    32'(err_cnt), 32'd0);
    check("rst_addr",   err_addr, 32'd0);
    check("rst_ssel",   32'(s_sel), 32'h04);
    check("dup_sel_id0", 32'(b_sel), 32'h1);
    drive(1'b1, T_IDLE, 32'h0100_0000);
    #1;
    check("dup_sel_id1", 32'(b_sel), 32'h0);
    check("ssel_slv1",   32'(s_sel), 32'h02);
    drive(1'b0, T_IDLE, 32'h0000_0000);
    #1;
    check("dup_sel_nosel", 32'(b_sel), 32'h0);
    hresetn = 1'b1;
    tick();

    // Mapped read to slave 3 with one wait state
    drive(1'b1, T_NONSEQ, 32'h0300_0010);
    @(negedge hclk);
    check("m_ssel",    32'(s_sel), 32'h08);
    check("m_addr_rdy", 32'(hready), 32'd1);
    tick();
    drive(1'b1, T_IDLE, 32'h0300_0010);
    s_hreadyout[3] = 1'b0;
    @(negedge hclk);
    check("m_wait_rdy", 32'(hready), 32'd0);
    tick();
    s_hreadyout[3] = 1'b1;
    s_hrdata[3*32 +: 32] = 32'h1234_5678;
    @(negedge hclk);
    check("m_done_rdy",   32'(hready), 32'd1);
    check("m_done_rdata", hrdata, 32'h1234_5678);
    check("m_done_resp",  32'(hresp), 32'd0);
    tick();
    @(negedge hclk);
    check("idle_rdata", hrdata, BAD);
    check("idle_rdy",   32'(hready), 32'd1);
    tick();

    // Unmapped access, then a second one issued in ERR2
    drive(1'b1, T_NONSEQ, 32'h0700_0000);
    @(negedge hclk);
    check("u_ssel", 32'(s_sel), 32'h00);
    tick();
    drive(1'b1, T_IDLE, 32'h0000_0000);
    @(negedge hclk);
    check("e1_rdy",  32'(hready), 32'd0);
    check("e1_resp", 32'(hresp), 32'd1);
    check("e1_rdata", hrdata, BAD);
    check("e1_irq",  32'(err_irq), 32'd1);
    check("e1_addr", err_addr, 32'h0700_0000);
    check("e1_cnt",  32'(err_cnt), 32'd1);
    tick();
    drive(1'b1, T_NONSEQ, 32'h0500_0004);
    @(negedge hclk);
    check("e2_rdy",  32'(hready), 32'd1);
    check("e2_resp", 32'(hresp), 32'd1);
    tick();
    drive(1'b1, T_IDLE, 32'h0000_0000);
    @(negedge hclk);
    check("re1_rdy",  32'(hready), 32'd0);
    check("re1_resp", 32'(hresp), 32'd1);
    check("re1_cnt",  32'(err_cnt), 32'd2);
    check("re1_addr", err_addr, 32'h0700_0000);
    tick();
    @(negedge hclk);
    check("re2_resp", 32'(hresp), 32'd1);
    tick();
    @(negedge hclk);
    check("back_idle_rdy",  32'(hready), 32'd1);
    check("back_idle_resp", 32'(hresp), 32'd0);

    // Mapped access accepted in ERR2
    drive(1'b1, T_NONSEQ, 32'h0600_0000);
    tick();
    drive(1'b1, T_IDLE, 32'h0000_0000);
    tick();
    drive(1'b1, T_NONSEQ, 32'h0100_0008);
    @(negedge hclk);
    check("e2m_resp", 32'(hresp), 32'd1);
    tick();
    drive(1'b1, T_IDLE, 32'h0000_0000);
    @(negedge hclk);
    check("e2m_rdy",   32'(hready), 32'd1);
    check("e2m_hresp", 32'(hresp), 32'd0);
    check("e2m_rdata", hrdata, 32'hA5A5_0001);
    check("e2m_cnt",   32'(err_cnt), 32'd3);
    tick();

    // Saturate the counter with 300 back-to-back unmapped accesses
    for (int k = 0; k < 300; k++) begin
      drive(1'b1, T_NONSEQ, 32'h0900_0000);
      tick();
      tick();
    end
    err_clr = 1'b1;
    drive(1'b1, T_NONSEQ, 32'h0F00_0020);
    @(negedge hclk);
    check("sat_cnt",  32'(err_cnt), 32'hFF);
    check("sat_irq",  32'(err_irq), 32'd1);
    check("sat_addr", err_addr, 32'h0700_0000);
    tick();
    err_clr = 1'b0;
    drive(1'b1, T_IDLE, 32'h0000_0000);
    @(negedge hclk);
    check("clrwin_cnt",  32'(err_cnt), 32'd1);
    check("clrwin_irq",  32'(err_irq), 32'd1);
    check("clrwin_addr", err_addr, 32'h0F00_0020);
    check("clrwin_rdy",  32'(hready), 32'd0);
    tick();
    tick();

    // Plain clear
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge hclk);
    check("clr_cnt",  32'(err_cnt), 32'd0);
    check("clr_irq",  32'(err_irq), 32'd0);
    check("clr_addr", err_addr, 32'd0);

    // Reset while in ERR1 aborts the error response
    drive(1'b1, T_NONSEQ, 32'h0800_0000);
    tick();
    drive(1'b1, T_IDLE, 32'h0000_0000);
    hresetn = 1'b0;
    @(negedge hclk);
    check("pre_rst_rdy", 32'(hready), 32'd0);
    check("pre_rst_irq", 32'(err_irq), 32'd1);
    tick();
    @(negedge hclk);
    check("arst_rdy",   32'(hready), 32'd1);
    check("arst_resp",  32'(hresp), 32'd0);
    check("arst_rdata", hrdata, BAD);
    check("arst_irq",   32'(err_irq), 32'd0);
    check("arst_cnt",   32'(err_cnt), 32'd0);
    check("arst_addr",  err_addr, 32'd0);
    hresetn = 1'b1;
    tick();
    @(negedge hclk);
    check("post_rst_resp", 32'(hresp), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
